conv11_output: RTL and testbench

CONV11_OUTPUT -- requirements
Module: conv11_output

---
 rtl/conv11_output_if.sv | 26 ++
 rtl/conv11_output.sv | 218 +++++++++++++++++++++
 tb/tb_conv11_output.sv | 257 +++++++++++++++++++++++++
 3 files changed

// File: rtl/conv11_output_if.sv
// Output byte stream of conv11_output: one requantised channel per
// valid/ready transfer, tagged with its channel index.
interface conv11_output_if #(
  parameter int OC = 8
);
  localparam int CH_W = (OC > 1) ? $clog2(OC) : 1;

  logic            out_valid;
  logic            out_ready;
  logic [7:0]      out_data;
  logic [CH_W-1:0] out_ch;

  modport master (
    output out_valid,
    output out_data,
    output out_ch,
    input  out_ready
  );

  modport slave (
    input  out_valid,
    input  out_data,
    input  out_ch,
    output out_ready
  );
endinterface

// File: rtl/conv11_output.sv
// Requantisation and serialisation stage for a 1x1 convolution: captures OC
// accumulators, then emits one saturated int8 per channel over a ready/valid stream.
module conv11_output #(
  parameter int OC    = 8,
  parameter int ACC_W = 32,
  parameter int SC_W  = 16,
  parameter int RELU  = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  calc_valid,
  input  logic [OC*ACC_W-1:0]   acc_data,
  input  logic [OC*ACC_W-1:0]   bias_data,
  input  logic [OC*SC_W-1:0]    scale_data,
  input  logic [4:0]            shift,
  input  logic                  output_en,
  conv11_output_if.master       out_if,
  output logic                  output_done,
  output logic                  busy,
  output logic                  overrun
);

  localparam int CH_W = (OC > 1) ? $clog2(OC) : 1;
  // One spare bit above the product so the rounding add cannot wrap.
  localparam int P_W  = ACC_W + SC_W + 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HOLD = 2'd1,
    EMIT = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t                  state_q, state_d;
  logic signed [ACC_W-1:0] acc_q   [OC];
  logic signed [ACC_W-1:0] acc_d   [OC];
  logic signed [ACC_W-1:0] bias_q  [OC];
  logic signed [ACC_W-1:0] bias_d  [OC];
  logic signed [SC_W-1:0]  scale_q [OC];
  logic signed [SC_W-1:0]  scale_d [OC];
  logic [4:0]              shift_q, shift_d;
  logic                    out_valid_q, out_valid_d;
  logic [7:0]              out_data_q, out_data_d;
  logic [CH_W-1:0]         out_ch_q, out_ch_d;
  logic                    output_done_q, output_done_d;
  logic                    busy_q, busy_d;
  logic                    overrun_q, overrun_d;
  logic [CH_W-1:0]         sel_s;
  logic [CH_W-1:0]         idx_s;
  logic [7:0]              res_s;

  function automatic logic [7:0] sat8(input logic signed [P_W-1:0] r);
    logic neg;
    logic hi_zero;
    logic hi_ones;
    logic [7:0] res;
    neg     = r[P_W-1];
    hi_zero = ~|r[P_W-2:7];
    hi_ones = &r[P_W-2:7];
    if (RELU != 0) begin
      if (neg) begin
        res = 8'd0;
      end else if (!hi_zero) begin
        res = 8'd127;
      end else begin
        res = r[7:0];
      end
    end else begin
      if (!neg && !hi_zero) begin
        res = 8'h7f;
      end else if (neg && !hi_ones) begin
        res = 8'h80;
      end else begin
        res = r[7:0];
      end
    end
    return res;
  endfunction

  function automatic logic [7:0] requant(
    input logic signed [ACC_W-1:0] acc,
    input logic signed [ACC_W-1:0] bias,
    input logic signed [SC_W-1:0]  scale,
    input logic [4:0]              sh
  );
    logic signed [ACC_W:0]  s;
    logic signed [P_W-1:0]  p;
    logic signed [P_W-1:0]  rnd;
    logic signed [P_W-1:0]  r;
    s = (ACC_W+1)'(acc) + (ACC_W+1)'(bias);
    p = P_W'(s) * P_W'(scale);
    if (sh != 5'd0) begin
      rnd = P_W'(1'b1) << (sh - 5'd1);
    end else begin
      rnd = {P_W{1'b0}};
    end
    r = (p + rnd) >>> sh;
    return sat8(r);
  endfunction

  // Channel to present at the next edge: 0 on the first EMIT cycle, else the successor.
  always_comb begin
    if (out_valid_q) begin
      sel_s = out_ch_q + CH_W'(1'b1);
    end else begin
      sel_s = {CH_W{1'b0}};
    end
    if (sel_s <= CH_W'(OC - 1)) begin
      idx_s = sel_s;
    end else begin
      idx_s = {CH_W{1'b0}};
    end
    res_s = requant(acc_q[idx_s], bias_q[idx_s], scale_q[idx_s], shift_q);
  end

  always_comb begin
    state_d       = state_q;
    acc_d         = acc_q;
    bias_d        = bias_q;
    scale_d       = scale_q;
    shift_d       = shift_q;
    out_valid_d   = out_valid_q;
    out_data_d    = out_data_q;
    out_ch_d      = out_ch_q;
    output_done_d = 1'b0;
    if (calc_valid && (state_q != IDLE)) begin
      overrun_d = 1'b1;
    end else begin
      overrun_d = overrun_q;
    end
    case (state_q)
      IDLE: begin
        if (calc_valid) begin
          state_d = HOLD;
          for (int k = 0; k < OC; k++) begin
            acc_d[k]   = acc_data[k*ACC_W +: ACC_W];
            bias_d[k]  = bias_data[k*ACC_W +: ACC_W];
            scale_d[k] = scale_data[k*SC_W +: SC_W];
          end
          shift_d = shift;
        end else begin
          state_d = IDLE;
        end
      end
      HOLD: begin
        if (output_en) begin
          state_d = EMIT;
        end else begin
          state_d = HOLD;
        end
      end
      EMIT: begin
        // output_en is deliberately not consulted here; only out_ready throttles.
        if (!out_valid_q) begin
          out_valid_d = 1'b1;
          out_ch_d    = sel_s;
          out_data_d  = res_s;
        end else if (out_if.out_ready) begin
          if (out_ch_q == CH_W'(OC - 1)) begin
            out_valid_d = 1'b0;
            state_d     = DONE;
          end else begin
            out_ch_d   = sel_s;
            out_data_d = res_s;
          end
        end else begin
          out_valid_d = out_valid_q;
        end
      end
      DONE: begin
        state_d       = IDLE;
        output_done_d = 1'b1;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      for (int k = 0; k < OC; k++) begin
        acc_q[k]   <= {ACC_W{1'b0}};
        bias_q[k]  <= {ACC_W{1'b0}};
        scale_q[k] <= {SC_W{1'b0}};
      end
      shift_q       <= 5'd0;
      out_valid_q   <= 1'b0;
      out_data_q    <= 8'd0;
      out_ch_q      <= {CH_W{1'b0}};
      output_done_q <= 1'b0;
      busy_q        <= 1'b0;
      overrun_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      acc_q         <= acc_d;
      bias_q        <= bias_d;
      scale_q       <= scale_d;
      shift_q       <= shift_d;
      out_valid_q   <= out_valid_d;
      out_data_q    <= out_data_d;
      out_ch_q      <= out_ch_d;
      output_done_q <= output_done_d;
      busy_q        <= busy_d;
      overrun_q     <= overrun_d;
    end
  end

  assign out_if.out_valid = out_valid_q;
  assign out_if.out_data  = out_data_q;
  assign out_if.out_ch    = out_ch_q;
  assign output_done      = output_done_q;
  assign busy             = busy_q;
  assign overrun          = overrun_q;

endmodule

// File: tb/tb_conv11_output.sv
// Directed bench for conv11_output: a RELU=1 and a RELU=0 instance share all
// stimulus and are checked against hand-computed bytes.
module tb_conv11_output;

  localparam int OC = 8;

  logic              clk;
  logic              rst_n;
  logic              calc_valid;
  logic [OC*32-1:0]  acc_data;
  logic [OC*32-1:0]  bias_data;
  logic [OC*16-1:0]  scale_data;
  logic [4:0]        shift;
  logic              output_en;
  logic              out_ready;
  logic              done1, busy1, ovr1;
  logic              done0, busy0, ovr0;

  int          n_test;
  int          n_fail;
  int          acc_v   [OC];
  int          bias_v  [OC];
  int          scale_v [OC];
  logic [7:0]  e1 [OC];
  logic [7:0]  e0 [OC];

  conv11_output_if #(.OC(OC)) if1 ();
  conv11_output_if #(.OC(OC)) if0 ();

  assign if1.out_ready = out_ready;
  assign if0.out_ready = out_ready;

  conv11_output #(.OC(OC), .ACC_W(32), .SC_W(16), .RELU(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .calc_valid(calc_valid),
    .acc_data(acc_data), .bias_data(bias_data), .scale_data(scale_data),
    .shift(shift), .output_en(output_en), .out_if(if1),
    .output_done(done1), .busy(busy1), .overrun(ovr1)
  );

  conv11_output #(.OC(OC), .ACC_W(32), .SC_W(16), .RELU(0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .calc_valid(calc_valid),
    .acc_data(acc_data), .bias_data(bias_data), .scale_data(scale_data),
    .shift(shift), .output_en(output_en), .out_if(if0),
    .output_done(done0), .busy(busy0), .overrun(ovr0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_test++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_vec(input logic [4:0] sh);
    for (int k = 0; k < OC; k++) begin
      acc_data[k*32 +: 32]   = acc_v[k];
      bias_data[k*32 +: 32]  = bias_v[k];
      scale_data[k*16 +: 16] = scale_v[k][15:0];
    end
    shift = sh;
  endtask

  task automatic start_vec();
    calc_valid = 1'b1;
    tick();
    calc_valid = 1'b0;
  endtask

  // Called just after the HOLD->EMIT edge. mode 0: ready high; mode 1: ready 1,0,0,1 and output_en dropped.
  task automatic run_stream(input int mode);
    logic       pv [2];
    logic [2:0] pc [2];
    logic [7:0] pd [2];
    logic       rdy;
    int         got_n;
    int         first_v;
    int         done_c;
    got_n   = 0;
    first_v = -1;
    done_c  = -1;
    chk("emit_entry_valid", if1.out_valid, 0);
    if (mode == 1) output_en = 1'b0;
    for (int i = 1; i <= 80; i++) begin
      if (done_c < 0) begin
        rdy = (mode == 0) || ((i - 1) % 4 == 0) || ((i - 1) % 4 == 3);
        out_ready = rdy;
        pv[0] = if1.out_valid; pc[0] = if1.out_ch; pd[0] = if1.out_data;
        pv[1] = if0.out_valid; pc[1] = if0.out_ch; pd[1] = if0.out_data;
        tick();
        if (pv[0] && !rdy) begin
          chk("stall_valid", if1.out_valid, 1);
          chk("stall_ch", if1.out_ch, pc[0]);
          chk("stall_data", if1.out_data, pd[0]);
          chk("stall_data_s", if0.out_data, pd[1]);
        end
        if (pv[0] && rdy) begin
          if (got_n < OC) begin
            chk("beat_ch", pc[0], got_n);
            chk("beat_ch_s", pc[1], got_n);
            chk("beat_relu", pd[0], e1[got_n]);
            chk("beat_signed", pd[1], e0[got_n]);
          end else begin
            chk("beat_extra", got_n, OC - 1);
          end
          got_n++;
        end
        if (if1.out_valid && (first_v < 0)) first_v = i;
        if (done1) done_c = i;
      end
    end
    out_ready = 1'b1;
    chk("beat_count", got_n, OC);
    if (mode == 0) begin
      chk("first_valid_cyc", first_v, 1);
      chk("done_latency", done_c, OC + 2);
    end else begin
      chk("done_seen", (done_c > 0), 1);
    end
    chk("done_s_same", done0, done1);
    chk("busy_at_done", busy1, 0);
    tick();
    chk("done_width", done1, 0);
    output_en = 1'b0;
  endtask

  task automatic set_s1();
    for (int k = 0; k < OC; k++) begin
      acc_v[k] = 100 * k; bias_v[k] = 0; scale_v[k] = 1;
    end
    apply_vec(5'd2);
    e1 = '{8'd0, 8'd25, 8'd50, 8'd75, 8'd100, 8'd125, 8'd127, 8'd127};
    e0 = e1;
  endtask

  initial begin
    int cnt_a;
    int cnt_b;
    n_test = 0;
    n_fail = 0;
    rst_n = 1'b0; calc_valid = 1'b0; output_en = 1'b0; out_ready = 1'b1;
    acc_data = '0; bias_data = '0; scale_data = '0; shift = 5'd0;
    tick(); tick();
    chk("rst_valid", if1.out_valid, 0);
    chk("rst_data", if1.out_data, 0);
    chk("rst_ch", if1.out_ch, 0);
    chk("rst_done", done1, 0);
    chk("rst_busy", busy1, 0);
    chk("rst_overrun", ovr1, 0);
    rst_n = 1'b1;
    tick();

    // Basic stream, ready high.
    set_s1();
    start_vec();
    chk("hold_busy", busy1, 1);
    output_en = 1'b1; tick();
    run_stream(0);

    // Rounding and signed saturation.
    acc_v   = '{-6, 6, -1000, 1000, 10, 1, -2, 7};
    bias_v  = '{0, 0, 0, 0, -30, 0, 0, 0};
    scale_v = '{1, 1, 1, 1, 3, 1, 1, -5};
    apply_vec(5'd2);
    e1 = '{8'h00, 8'h02, 8'h00, 8'h7f, 8'h00, 8'h00, 8'h00, 8'h00};
    e0 = '{8'hff, 8'h02, 8'h80, 8'h7f, 8'hf1, 8'h00, 8'h00, 8'hf7};
    start_vec();
    output_en = 1'b1; tick();
    run_stream(0);

    // Backpressure with output_en dropped mid-stream.
    for (int k = 0; k < OC; k++) begin
      acc_v[k] = 7 * k - 20; bias_v[k] = 0; scale_v[k] = 16;
    end
    apply_vec(5'd4);
    e1 = '{8'h00, 8'h00, 8'h00, 8'h01, 8'h08, 8'h0f, 8'h16, 8'h1d};
    e0 = '{8'hec, 8'hf3, 8'hfa, 8'h01, 8'h08, 8'h0f, 8'h16, 8'h1d};
    start_vec();
    output_en = 1'b1; tick();
    run_stream(1);
    chk("overrun_clear", ovr1, 0);

    // Overrun: second vector in HOLD is ignored.
    for (int k = 0; k < OC; k++) begin
      acc_v[k] = 3 * k - 10; bias_v[k] = 5; scale_v[k] = 2;
    end
    apply_vec(5'd0);
    e1 = '{8'h00, 8'h00, 8'h02, 8'h08, 8'h0e, 8'h14, 8'h1a, 8'h20};
    e0 = '{8'hf6, 8'hfc, 8'h02, 8'h08, 8'h0e, 8'h14, 8'h1a, 8'h20};
    start_vec();
    chk("overrun_before", ovr1, 0);
    for (int k = 0; k < OC; k++) acc_data[k*32 +: 32] = 32'd99;
    start_vec();
    chk("overrun_set", ovr1, 1);
    chk("overrun_set_s", ovr0, 1);
    output_en = 1'b1; tick();
    run_stream(0);
    chk("overrun_sticky", ovr1, 1);

    // Reset after channel 3 is accepted.
    set_s1();
    start_vec();
    output_en = 1'b1; tick();
    for (int i = 0; i < 5; i++) tick();
    chk("pre_rst_ch", if1.out_ch, 4);
    rst_n = 1'b0;
    tick();
    chk("mid_rst_valid", if1.out_valid, 0);
    chk("mid_rst_data", if1.out_data, 0);
    chk("mid_rst_ch", if1.out_ch, 0);
    chk("mid_rst_busy", busy1, 0);
    chk("mid_rst_busy_s", busy0, 0);
    chk("mid_rst_overrun", ovr1, 0);
    rst_n = 1'b1; output_en = 1'b0;
    cnt_a = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (done1 || if1.out_valid) cnt_a++;
    end
    chk("no_done_after_rst", cnt_a, 0);
    start_vec();
    output_en = 1'b1; tick();
    run_stream(0);

    // Gating: output_en low keeps the vector parked in HOLD.
    for (int k = 0; k < OC; k++) begin
      acc_v[k] = 7 * k - 20; bias_v[k] = 0; scale_v[k] = 16;
    end
    apply_vec(5'd4);
    e1 = '{8'h00, 8'h00, 8'h00, 8'h01, 8'h08, 8'h0f, 8'h16, 8'h1d};
    e0 = '{8'hec, 8'hf3, 8'hfa, 8'h01, 8'h08, 8'h0f, 8'h16, 8'h1d};
    start_vec();
    cnt_a = 0;
    cnt_b = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (if1.out_valid) cnt_a++;
      if (!busy1) cnt_b++;
    end
    chk("gate_valid_cnt", cnt_a, 0);
    chk("gate_idle_cnt", cnt_b, 0);
    output_en = 1'b1; tick();
    run_stream(0);

    $display("[TB] %0d tests run, %0d failed", n_test, n_fail);
    $finish;
  end

endmodule
